aes_sbox_sched: RTL

- Shares a small bank of S-box lookup lanes between two requesters: the round datapath (128-bit SubBytes) and the key expansion (32-bit SubWord).
- The state request is processed over 16/NSBOX passes; a key word is processed in one pass.
- Sits between the round controller / key scheduler and the S-box lanes. It replaces 20 parallel S-boxes (16 for the state, 4 for key words) with NSBOX lanes.

---
 rtl/aes_sbox_pkg.sv | 25 ++
 rtl/sbox_bank.sv | 35 +++
 rtl/aes_sbox_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared widths, FSM/grant encodings and byte addressing for the S-box scheduler.
package aes_sbox_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;
  localparam int NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } fsm_t;

  typedef enum logic {
    STATE = 1'b0,
    KEY   = 1'b1
  } grant_t;

  // LSB position of byte idx inside a 128-bit state (byte 0 is the MSB).
  function automatic int byte_lsb(input int idx);
    return STATE_W - BYTE_W * (idx + 1);
  endfunction

endpackage

// File: rtl/sbox_bank.sv
// Combinational bank of NSBOX AES S-box lookups built from a 256-entry table.

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry v lives at bits (255-v)*8 +: 8, i.e. entry 0 is the most significant byte.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - din) * 8 computed as {~din, 3'b000}.
  assign dout = TABLE[{~din, 3'b000} +: 8];
endmodule

module sbox_bank #(
  parameter int NSBOX = 4
) (
  input  logic [NSBOX*8-1:0] in,
  output logic [NSBOX*8-1:0] out
);
  for (genvar k = 0; k < NSBOX; k++) begin : g_lane
    aes_sbox u_sbox (
      .din  (in[k*8 +: 8]),
      .dout (out[k*8 +: 8])
    );
  end
endmodule

// File: rtl/aes_sbox_sched.sv
// Time-shares NSBOX S-box lanes between the round datapath (SubBytes on a
// 128-bit state, 16/NSBOX passes) and the key schedule (SubWord, one pass).
module aes_sbox_sched
  import aes_sbox_pkg::*;
#(
  parameter int NSBOX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [STATE_W-1:0] st_in,
  output logic               st_out_valid,
  output logic [STATE_W-1:0] st_out,
  input  logic               kw_valid,
  output logic               kw_ready,
  input  logic [WORD_W-1:0]  kw_in,
  output logic               kw_out_valid,
  output logic [WORD_W-1:0]  kw_out,
  output logic               busy
);

  if (!((NSBOX == 4) || (NSBOX == 8) || (NSBOX == 16))) begin : g_bad_nsbox
    $error("aes_sbox_sched: NSBOX must be 4, 8 or 16");
  end

  localparam int NPASS  = NBYTES / NSBOX;
  localparam int LANE_W = NSBOX * BYTE_W;

  fsm_t               state_r;
  grant_t             last_grant_r;
  logic [1:0]         pass_r;
  logic [STATE_W-1:0] work_r;
  logic [LANE_W-1:0]  lane_in_s;
  logic [LANE_W-1:0]  lane_out_s;
  logic [STATE_W-1:0] work_next_s;
  int                 base_s;
  logic               last_pass_s;

  // Both requesters see ready only while idle and out of reset.
  assign st_ready    = (state_r == IDLE) && !rst;
  assign kw_ready    = (state_r == IDLE) && !rst;
  assign last_pass_s = (pass_r == 2'(NPASS - 1));

  // Lane input mux: state passes walk through the working bytes, a key word
  // sits in bytes 0..3 so lanes 0..3 see kw bytes 0..3.
  always_comb begin
    lane_in_s = '0;
    if (state_r == ST_RUN) begin
      base_s = int'(pass_r) * NSBOX;
    end else begin
      base_s = 0;
    end
    for (int k = 0; k < NSBOX; k++) begin
      lane_in_s[k*BYTE_W +: BYTE_W] = work_r[byte_lsb(base_s + k) +: BYTE_W];
    end
  end

  sbox_bank #(.NSBOX(NSBOX)) u_bank (
    .in  (lane_in_s),
    .out (lane_out_s)
  );

  // Write lane results back over the bytes they were read from.
  always_comb begin
    work_next_s = work_r;
    for (int k = 0; k < NSBOX; k++) begin
      work_next_s[byte_lsb(base_s + k) +: BYTE_W] = lane_out_s[k*BYTE_W +: BYTE_W];
    end
  end

  // Scheduler FSM: round-robin arbitration, pass sequencing and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= STATE;
      pass_r       <= 2'd0;
      work_r       <= '0;
      st_out       <= '0;
      kw_out       <= '0;
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // Key wins when alone or when the state was served last.
          if (kw_valid && (!st_valid || (last_grant_r == STATE))) begin
            work_r       <= {kw_in, {(STATE_W - WORD_W){1'b0}}};
            last_grant_r <= KEY;
            state_r      <= KW_RUN;
            busy         <= 1'b1;
          end else if (st_valid) begin
            work_r       <= st_in;
            pass_r       <= 2'd0;
            last_grant_r <= STATE;
            state_r      <= ST_RUN;
            busy         <= 1'b1;
          end else begin
            busy         <= 1'b0;
          end
        end
        KW_RUN: begin
          kw_out       <= work_next_s[STATE_W-1 -: WORD_W];
          kw_out_valid <= 1'b1;
          state_r      <= IDLE;
          busy         <= 1'b0;
        end
        ST_RUN: begin
          work_r <= work_next_s;
          if (last_pass_s) begin
            st_out       <= work_next_s;
            st_out_valid <= 1'b1;
            pass_r       <= 2'd0;
            state_r      <= IDLE;
            busy         <= 1'b0;
          end else begin
            pass_r       <= pass_r + 2'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
